// File: rtl/dpram_fifo_if.sv
// Stream, status and RAM-port signals of the dual-port-RAM FIFO controller.
// The controller takes the slave modport; the environment/RAM side takes master.
interface dpram_fifo_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              flush;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W+1:0] count;
  logic              full;
  logic              empty;
  logic [ADDR_W-1:0] ram_addr_a;
  logic [DATA_W-1:0] ram_din_a;
  logic              ram_we_a;
  logic              ram_re_a;
  logic [ADDR_W-1:0] ram_addr_b;
  logic [DATA_W-1:0] ram_din_b;
  logic              ram_we_b;
  logic              ram_re_b;
  logic [DATA_W-1:0] ram_dout_b;

  modport slave (
    input  flush, s_valid, s_data, m_ready, ram_dout_b,
    output s_ready, m_valid, m_data, count, full, empty,
           ram_addr_a, ram_din_a, ram_we_a, ram_re_a,
           ram_addr_b, ram_din_b, ram_we_b, ram_re_b
  );

  modport master (
    output flush, s_valid, s_data, m_ready, ram_dout_b,
    input  s_ready, m_valid, m_data, count, full, empty,
           ram_addr_a, ram_din_a, ram_we_a, ram_re_a,
           ram_addr_b, ram_din_b, ram_we_b, ram_re_b
  );
endinterface

// File: rtl/dpram_fifo_ctrl.sv
// 16-deep stream FIFO controller around a dual-port RAM: port A writes the
// producer stream, port B prefetches into a 2-entry output queue.
module dpram_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic         clk,
  input  logic         rst,
  dpram_fifo_if.slave  bus
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int OUT_W = ADDR_W + 2;

  logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       mem_cnt_q, mem_cnt_d;
  logic                   inflight_q, inflight_d;
  logic [1:0][DATA_W-1:0] oq_q, oq_d;
  logic [1:0]             oq_cnt_q, oq_cnt_d;

  logic       s_ready_c, m_valid_c;
  logic       push, pop, fetch;
  logic [2:0] oq_claim;
  logic [1:0] oq_cnt_shift;

  always_comb begin
    s_ready_c = !rst && (mem_cnt_q != CNT_W'(DEPTH));
    m_valid_c = (oq_cnt_q != 2'd0);
    push      = bus.s_valid && s_ready_c && !bus.flush;
    pop       = m_valid_c && bus.m_ready;
    // Queue slots already owned by held or in-flight words, net of this pop.
    oq_claim  = 3'(oq_cnt_q) + 3'(inflight_q) - 3'(pop);
    fetch     = !rst && !bus.flush && (mem_cnt_q != '0) && (oq_claim < 3'd2);
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    mem_cnt_d    = mem_cnt_q;
    inflight_d   = inflight_q;
    oq_d         = oq_q;
    oq_cnt_d     = oq_cnt_q;
    oq_cnt_shift = oq_cnt_q;
    if (bus.flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      mem_cnt_d  = '0;
      inflight_d = 1'b0;
      oq_cnt_d   = '0;
    end else begin
      wr_ptr_d   = wr_ptr_q + ADDR_W'(push);
      rd_ptr_d   = rd_ptr_q + ADDR_W'(fetch);
      mem_cnt_d  = mem_cnt_q + CNT_W'(push) - CNT_W'(fetch);
      inflight_d = fetch;
      if (pop) begin
        oq_d[0]      = oq_q[1];
        oq_cnt_shift = oq_cnt_q - 2'd1;
      end
      // Returning RAM word lands behind whatever survives the pop.
      if (inflight_q) begin
        if (oq_cnt_shift == 2'd0) oq_d[0] = bus.ram_dout_b;
        else                      oq_d[1] = bus.ram_dout_b;
        oq_cnt_d = oq_cnt_shift + 2'd1;
      end else begin
        oq_cnt_d = oq_cnt_shift;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      inflight_q <= 1'b0;
      oq_q       <= '0;
      oq_cnt_q   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_cnt_q  <= mem_cnt_d;
      inflight_q <= inflight_d;
      oq_q       <= oq_d;
      oq_cnt_q   <= oq_cnt_d;
    end
  end

  assign bus.s_ready    = s_ready_c;
  assign bus.m_valid    = m_valid_c;
  assign bus.m_data     = oq_q[0];
  assign bus.count      = OUT_W'(mem_cnt_q) + OUT_W'(inflight_q) + OUT_W'(oq_cnt_q);
  assign bus.full       = (mem_cnt_q == CNT_W'(DEPTH));
  assign bus.empty      = (mem_cnt_q == '0) && !inflight_q && (oq_cnt_q == 2'd0);
  assign bus.ram_addr_a = wr_ptr_q;
  assign bus.ram_din_a  = bus.s_data;
  assign bus.ram_we_a   = push;
  assign bus.ram_re_a   = 1'b0;
  assign bus.ram_addr_b = rd_ptr_q;
  assign bus.ram_din_b  = '0;
  assign bus.ram_we_b   = 1'b0;
  assign bus.ram_re_b   = fetch;

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Directed bench for dpram_fifo_ctrl with a behavioural 16x8 RAM and an
// in-order scoreboard fed by accepted pushes and drained by pops.
module tb_dpram_fifo_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dpram_fifo_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  dpram_fifo_ctrl #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] ram_mem [16];
  logic [7:0] ram_dout;
  assign bus.ram_dout_b = ram_dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ram_dout <= '0;
    else begin
      if (bus.ram_we_a) ram_mem[bus.ram_addr_a] <= bus.ram_din_a;
      if (bus.ram_re_b) ram_dout <= ram_mem[bus.ram_addr_b];
    end
  end

  int n_assert = 0;
  int n_fail   = 0;
  int rd_wraps = 0;
  logic [7:0] sb[$];
  logic [3:0] exp_rd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input string tag);
    bit done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      tick();
      if (bus.empty) done = 1'b1;
    end
    chk(tag, done, 1'b1);
  endtask

  // Scoreboard and fetch-address model, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      exp_rd = '0;
    end else begin
      if (bus.ram_re_b) begin
        chk("rd_addr", bus.ram_addr_b, exp_rd);
        if (exp_rd == 4'd15) rd_wraps++;
        exp_rd = exp_rd + 4'd1;
      end
      if (bus.m_valid && bus.m_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 1'b0, 1'b1);
        else chk("m_data_order", bus.m_data, sb.pop_front());
      end
      if (bus.flush) begin
        sb.delete();
        exp_rd = '0;
      end else if (bus.s_valid && bus.s_ready) begin
        sb.push_back(bus.s_data);
      end
    end
  end

  initial begin
    bus.flush   = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;

    // Reset asserted mid-cycle
    #3 rst = 1'b1;
    #1;
    chk("rst_empty",   bus.empty,    1'b1);
    chk("rst_count",   bus.count,    6'd0);
    chk("rst_m_valid", bus.m_valid,  1'b0);
    chk("rst_s_ready", bus.s_ready,  1'b0);
    chk("rst_full",    bus.full,     1'b0);
    chk("rst_m_data",  bus.m_data,   8'h00);
    chk("rst_we_a",    bus.ram_we_a, 1'b0);
    chk("rst_re_b",    bus.ram_re_b, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("rel_s_ready", bus.s_ready, 1'b1);

    // Single word
    tick();
    bus.m_ready = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h5A;
    #1;
    chk("sw_we_a",   bus.ram_we_a,   1'b1);
    chk("sw_addr_a", bus.ram_addr_a, 4'd0);
    tick();
    bus.s_valid = 1'b0;
    #1;
    chk("sw_re_b",   bus.ram_re_b,   1'b1);
    chk("sw_addr_b", bus.ram_addr_b, 4'd0);
    chk("sw_mv_e0",  bus.m_valid,    1'b0);
    tick();
    chk("sw_mv_e1",  bus.m_valid,    1'b0);
    tick();
    chk("sw_mv_e2",  bus.m_valid,    1'b1);
    chk("sw_data",   bus.m_data,     8'h5A);
    tick();
    chk("sw_empty",  bus.empty,      1'b1);
    chk("sw_mv_pop", bus.m_valid,    1'b0);

    // Fill and hold, starting from cleared pointers
    bus.flush = 1'b1;
    tick();
    bus.flush   = 1'b0;
    bus.m_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 8'(i);
      #1;
      if (i == 16) chk("fill_wr_wrap", bus.ram_addr_a, 4'd0);
      tick();
    end
    bus.s_data = 8'h12;
    #1;
    chk("fill_count",   bus.count,      6'd18);
    chk("fill_full",    bus.full,       1'b1);
    chk("fill_s_ready", bus.s_ready,    1'b0);
    chk("fill_we_a",    bus.ram_we_a,   1'b0);
    chk("fill_addr_a",  bus.ram_addr_a, 4'd2);
    tick();
    chk("fill_hold",    bus.count,      6'd18);

    // Drain with continued pushes; head must never go invalid
    bus.m_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 8'h20 + 8'(i);
      tick();
      chk("drain_m_valid", bus.m_valid, 1'b1);
    end
    bus.s_valid = 1'b0;
    wait_empty("drain_empty");
    chk("drain_rd_wrap", rd_wraps > 0, 1'b1);
    chk("drain_sb_left", sb.size(), 0);

    // Streaming from empty
    for (int i = 0; i < 40; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 8'($urandom);
      tick();
      if (i == 1) chk("stream_lat_mv", bus.m_valid, 1'b0);
      if (i >= 2) chk("stream_m_valid", bus.m_valid, 1'b1);
      // steady stream holds a just-written word, one in flight and the head
      chk("stream_count_le3", bus.count <= 6'd3, 1'b1);
    end
    bus.s_valid = 1'b0;
    wait_empty("stream_empty");

    // Flush with 5 words queued and a fetch in flight
    bus.m_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 8'h90 + 8'(i);
      tick();
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    chk("fl_pre_count", bus.count, 6'd5);
    bus.flush   = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hEE;
    #1;
    chk("fl_we_a", bus.ram_we_a, 1'b0);
    chk("fl_re_b", bus.ram_re_b, 1'b0);
    tick();
    bus.flush   = 1'b0;
    bus.s_valid = 1'b0;
    chk("fl_count",   bus.count,   6'd0);
    chk("fl_m_valid", bus.m_valid, 1'b0);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hC3;
    #1;
    chk("fl_c3_we",   bus.ram_we_a,   1'b1);
    chk("fl_c3_addr", bus.ram_addr_a, 4'd0);
    tick();
    bus.s_valid = 1'b0;
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
        tick();
        if (bus.m_valid) seen = 1'b1;
      end
      chk("fl_c3_valid", seen, 1'b1);
      chk("fl_c3_data",  bus.m_data, 8'hC3);
    end
    bus.m_ready = 1'b1;
    wait_empty("fl_empty");
    chk("fl_sb_left", sb.size(), 0);

    // Reset in the middle of traffic
    bus.m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 8'h70 + 8'(i);
      tick();
    end
    #2 rst = 1'b1;
    #1;
    chk("mr_count",   bus.count,    6'd0);
    chk("mr_empty",   bus.empty,    1'b1);
    chk("mr_s_ready", bus.s_ready,  1'b0);
    chk("mr_we_a",    bus.ram_we_a, 1'b0);
    chk("mr_re_b",    bus.ram_re_b, 1'b0);
    chk("mr_m_valid", bus.m_valid,  1'b0);
    tick();
    #2 rst = 1'b0;
    #1;
    chk("mr_rel_s_ready", bus.s_ready, 1'b1);
    bus.s_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
